// File: rtl/systolic_array_ctrl.sv
// Sequencer for an N x N systolic matmul array: clear, skewed operand feed, row-by-row result drain.
// Feed lanes are zero-padded and skewed by lane index; the drain holds row/data steady while res_ready_i is low.
module systolic_array_ctrl #(
    parameter int N      = 4,
    parameter int K_MAX  = 16,
    parameter int DATA_W = 8,
    parameter int MAC_W  = 32,
    parameter int AW     = $clog2(K_MAX),
    localparam int KLW   = $clog2(K_MAX + 1),
    localparam int RW    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [KLW-1:0]        k_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  a_rd_en_o,
    output logic [AW-1:0]         a_rd_addr_o,
    input  logic [N*DATA_W-1:0]   a_rd_data_i,
    output logic                  b_rd_en_o,
    output logic [AW-1:0]         b_rd_addr_o,
    input  logic [N*DATA_W-1:0]   b_rd_data_i,
    output logic [N*DATA_W-1:0]   arr_a_west_o,
    output logic [N*DATA_W-1:0]   arr_b_north_o,
    output logic                  pe_load_o,
    output logic                  pe_clr_o,
    input  logic [N*N*MAC_W-1:0]  arr_result_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [RW-1:0]         res_row_o,
    output logic [N*MAC_W-1:0]    res_data_o
);
    localparam int CW = $clog2(K_MAX + 2*N);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KLW-1:0]   k_q, k_d;
    logic [RW-1:0]    row_q, row_d;
    logic             rd_vld_q;
    logic             feed_rd;
    logic [CW-1:0]    feed_last;
    logic [N*DATA_W-1:0] a_gated, b_gated;

    // Last FEED cycle is where PE(N-1,N-1) consumes its final product.
    assign feed_last = CW'(k_q) + CW'(2*N - 2);
    assign feed_rd   = (state_q == S_FEED) && (cnt_q < CW'(k_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_d     = (k_len_i > KLW'(K_MAX)) ? KLW'(K_MAX) : k_len_i;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                row_d   = '0;
                state_d = (k_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == feed_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_ready_i) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        pe_clr_o    = (state_q == S_CLEAR);
        pe_load_o   = (state_q == S_FEED) && (cnt_q != '0);
        res_valid_o = (state_q == S_DRAIN);
        a_rd_en_o   = feed_rd;
        b_rd_en_o   = feed_rd;
        a_rd_addr_o = feed_rd ? cnt_q[AW-1:0] : '0;
        b_rd_addr_o = feed_rd ? cnt_q[AW-1:0] : '0;
        res_row_o   = row_q;
        res_data_o  = '0;
        for (int j = 0; j < N; j++) begin
            res_data_o[j*MAC_W +: MAC_W] = arr_result_i[(int'(row_q)*N + j)*MAC_W +: MAC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            k_q      <= '0;
            row_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            row_q    <= row_d;
            rd_vld_q <= feed_rd;
        end
    end

    // Read data is only meaningful the cycle after a strobe; otherwise feed zeros.
    assign a_gated = rd_vld_q ? a_rd_data_i : '0;
    assign b_gated = rd_vld_q ? b_rd_data_i : '0;

    assign arr_a_west_o[0 +: DATA_W]  = a_gated[0 +: DATA_W];
    assign arr_b_north_o[0 +: DATA_W] = b_gated[0 +: DATA_W];

    for (genvar gi = 1; gi < N; gi++) begin : g_skew
        logic [DATA_W-1:0] a_dly_q [gi];
        logic [DATA_W-1:0] b_dly_q [gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d < gi; d++) begin
                    a_dly_q[d] <= '0;
                    b_dly_q[d] <= '0;
                end
            end else begin
                a_dly_q[0] <= a_gated[gi*DATA_W +: DATA_W];
                b_dly_q[0] <= b_gated[gi*DATA_W +: DATA_W];
                for (int d = 1; d < gi; d++) begin
                    a_dly_q[d] <= a_dly_q[d-1];
                    b_dly_q[d] <= b_dly_q[d-1];
                end
            end
        end

        assign arr_a_west_o[gi*DATA_W +: DATA_W]  = a_dly_q[gi-1];
        assign arr_b_north_o[gi*DATA_W +: DATA_W] = b_dly_q[gi-1];
    end

endmodule
